// File: rtl/left_shift_deserializer_ctrl.sv
// Serial-to-parallel controller: shifts DEPTH handshaked bits into a left-shift
// register and offers the completed word on a valid/ready port.

module left_shift_register_base #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in,
    output logic [DEPTH-1:0] out
);

    always_ff @(posedge clk) begin
        if (reset)
            out <= '0;
        else if (enable)
            out <= {out[DEPTH-2:0], in};
    end

endmodule

module left_shift_deserializer_ctrl #(
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    input  logic             s_data,
    output logic             s_ready,
    output logic             m_valid,
    output logic [DEPTH-1:0] m_data,
    input  logic             m_ready,
    input  logic             flush,
    output logic [CNT_W-1:0] bit_count
);

    typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

    state_t           state;
    logic             s_fire;
    logic             m_fire;
    logic             sr_clear;
    logic [DEPTH-1:0] sr_q;

    assign s_ready  = (state != FULL) && !flush;
    assign m_valid  = (state == FULL);
    assign s_fire   = s_valid && s_ready;
    assign m_fire   = m_valid && m_ready;
    assign sr_clear = !reset || flush || m_fire;

    // The register may hold stale bits right after an async reset pulse that
    // saw no clock edge; gating on m_valid keeps the output clean regardless.
    assign m_data   = m_valid ? sr_q : '0;

    left_shift_register_base #(.DEPTH(DEPTH)) u_sr (
        .clk    (clk),
        .reset  (sr_clear),
        .enable (s_fire),
        .in     (s_data),
        .out    (sr_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_count <= '0;
        end else if (flush) begin
            state     <= IDLE;
            bit_count <= '0;
        end else begin
            case (state)
                FULL: begin
                    if (m_ready) begin
                        state     <= IDLE;
                        bit_count <= '0;
                    end
                end
                default: begin
                    if (s_fire) begin
                        bit_count <= bit_count + 1'b1;
                        state     <= (bit_count == CNT_W'(DEPTH - 1)) ? FULL : SHIFT;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_left_shift_deserializer_ctrl.sv
// Self-checking bench: directed vector table, corner-case sequences and a
// randomized run, all compared against a word-level reference model.

module tb_left_shift_deserializer_ctrl;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             s_valid, s_data, s_ready;
    logic             m_valid, m_ready, flush;
    logic [DEPTH-1:0] m_data;
    logic [CNT_W-1:0] bit_count;

    int checks = 0;
    int errors = 0;

    // reference model: bits held and word value accumulated arithmetically
    int unsigned mcount;
    int unsigned mword;

    typedef struct {
        logic       sv;
        logic       sd;
        logic       mr;
        logic       fl;
        int         cnt;
        logic       mv;
        logic [7:0] md;
        logic       sr;
    } vec_t;

    vec_t vecs[14];

    left_shift_deserializer_ctrl #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .flush     (flush),
        .bit_count (bit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mcount = 0;
        mword  = 0;
    endtask

    task automatic model_edge(input logic sv, input logic sd, input logic mr, input logic fl);
        bit full, rdy;
        full = (mcount == DEPTH);
        rdy  = !full && !fl;
        if (fl || (full && mr)) begin
            mcount = 0;
            mword  = 0;
        end else if (sv && rdy) begin
            mword  = (mword * 2 + sd) % (1 << DEPTH);
            mcount = mcount + 1;
        end
    endtask

    task automatic compare_model(input string tag);
        bit full;
        full = (mcount == DEPTH);
        check({tag, ".bit_count"}, int'(bit_count), int'(mcount));
        check({tag, ".m_valid"},   int'(m_valid),   int'(full));
        check({tag, ".m_data"},    int'(m_data),    full ? int'(mword) : 0);
        check({tag, ".s_ready"},   int'(s_ready),   int'(!full && !flush));
    endtask

    // drive, clock, idle inputs, then sample away from the edge
    task automatic step(input logic sv, input logic sd, input logic mr, input logic fl);
        s_valid = sv; s_data = sd; m_ready = mr; flush = fl;
        @(posedge clk);
        model_edge(sv, sd, mr, fl);
        #1;
        s_valid = 1'b0; s_data = 1'b0; m_ready = 1'b0; flush = 1'b0;
        #1;
    endtask

    task automatic stream(input logic [7:0] w);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            step(1'b1, w[i], 1'b0, 1'b0);
            compare_model("stream");
        end
    endtask

    initial begin
        logic [7:0] pat;
        logic [3:0] tog_bits;
        int         tog_cnt[7];

        // first word 11010110 then 5 stalled cycles then accept
        pat = 8'b11010110;
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{1'b1, pat[7-i], 1'b0, 1'b0, i + 1, (i == 7), (i == 7) ? 8'hD6 : 8'h00, (i != 7)};
        end
        for (int i = 8; i < 13; i++) vecs[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b1, 8'hD6, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b1};

        s_valid = 1'b0; s_data = 1'b0; m_ready = 1'b0; flush = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        check("reset.bit_count", int'(bit_count), 0);
        check("reset.m_valid",   int'(m_valid),   0);
        check("reset.m_data",    int'(m_data),    0);
        check("reset.s_ready",   int'(s_ready),   1);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].sv, vecs[i].sd, vecs[i].mr, vecs[i].fl);
            check($sformatf("vec%0d.bit_count", i), int'(bit_count), vecs[i].cnt);
            check($sformatf("vec%0d.m_valid", i),   int'(m_valid),   int'(vecs[i].mv));
            check($sformatf("vec%0d.m_data", i),    int'(m_data),    int'(vecs[i].md));
            check($sformatf("vec%0d.s_ready", i),   int'(s_ready),   int'(vecs[i].sr));
        end

        // eight ones
        stream(8'hFF);
        check("ones.m_data", int'(m_data), 8'hFF);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        compare_model("ones_ack");

        // s_valid toggling
        tog_bits = 4'b1010;
        tog_cnt  = '{1, 1, 2, 2, 3, 3, 4};
        for (int i = 0; i < 7; i++) begin
            if (i % 2 == 0) step(1'b1, tog_bits[3 - i/2], 1'b0, 1'b0);
            else            step(1'b0, 1'b1, 1'b0, 1'b0);
            check($sformatf("toggle%0d.bit_count", i), int'(bit_count), tog_cnt[i]);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        compare_model("toggle_flush");

        // flush at bit_count 5 with s_valid high
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("preflush.bit_count", int'(bit_count), 5);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("flush.bit_count", int'(bit_count), 0);
        stream(8'b10101010);
        check("postflush.m_data", int'(m_data), 8'hAA);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // async reset mid-word
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("prereset.bit_count", int'(bit_count), 3);
        #1 reset = 1'b0;
        #1;
        check("areset.bit_count", int'(bit_count), 0);
        check("areset.m_valid",   int'(m_valid),   0);
        check("areset.m_data",    int'(m_data),    0);
        model_reset();
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("postreset7.m_valid", int'(m_valid), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("postreset8.m_valid", int'(m_valid), 1);
        check("postreset8.m_data",  int'(m_data),  8'h01);

        // flush together with m_ready in FULL
        s_valid = 1'b0; m_ready = 1'b1; flush = 1'b1;
        @(posedge clk);
        model_edge(1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        m_ready = 1'b0;
        check("flushack.m_valid",  int'(m_valid), 0);
        check("flushack.s_ready",  int'(s_ready), 0);
        flush = 1'b0;
        #1;
        check("flushack.s_ready_after", int'(s_ready), 1);
        compare_model("flushack");

        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 24) == 0));
            compare_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/left_shift_deserializer_ctrl.md
# left_shift_deserializer_ctrl

Controller that sequences a `left_shift_register_base` instance to turn a serial bit stream into parallel words. Each serial bit is accepted on a valid/ready handshake and shifted in. After `DEPTH` bits, the block presents the word on a valid/ready output port and holds it until the consumer accepts it. It sits between a serial source (UART/SPI-style front end) and any word-wide consumer in the shifting library.

## Interface
- `DEPTH`, default 8: word width and number of bits per word; must be >= 2.
- `CNT_W`, default `$clog2(DEPTH+1)`: width of the bit counter; local, not overridable.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `s_valid`  in  1  serial source has a bit on `s_data`.
- `s_data`  in  1  serial bit; the first bit of a word ends up in `m_data[DEPTH-1]`.
- `s_ready`  out  1  block can accept a serial bit this cycle.
- `m_valid`  out  1  complete word present on `m_data`.
- `m_data`  out  DEPTH  parallel word; reads 0 whenever `m_valid`=0.
- `m_ready`  in  1  consumer accepts the word this cycle.
- `flush`  in  1  synchronous abort: discard the partial or complete word.
- `bit_count`  out  CNT_W  number of bits currently held (0..DEPTH).

## Operation
- Internal `left_shift_register_base #(.DEPTH(DEPTH))` instance:
  - its `in` is `s_data`;
  - its `enable` is `s_fire` = `s_valid && s_ready`;
  - its `reset` (active-high clear) = `!reset || flush || m_fire`, where `m_fire` = `m_valid && m_ready`.
- States:
  - IDLE: `bit_count`=0.
  - SHIFT: 0 < `bit_count` < `DEPTH`.
  - FULL: `bit_count`=`DEPTH`.
- `s_ready` = (state != FULL) && !`flush`.
- `m_valid` = (state == FULL). It is a decode of registered state, so it is glitch-free.
- Transitions, evaluated at each rising edge in priority order:
  1. `flush`=1: go to IDLE, `bit_count` to 0, register cleared. Applies in every state; in FULL the word is discarded unless `m_ready` is also 1, in which case the transfer still counts because the consumer saw valid && ready.
  2. FULL with `m_fire`: go to IDLE, `bit_count` to 0, register cleared.
  3. IDLE/SHIFT with `s_fire`: `bit_count` +1 and register shifts left with `s_data` entering bit 0. If `bit_count` was `DEPTH`-1, go to FULL; otherwise go to (or stay in) SHIFT.
  4. Otherwise hold.
- `bit_count` never exceeds `DEPTH` and never wraps; it saturates by construction because FULL blocks `s_ready`.
- No bit is accepted in the same cycle a word leaves; the next word starts at the earliest one cycle after `m_fire`.
- Reset (`reset`=0, asynchronous):
  - state IDLE, `bit_count`=0, `m_valid`=0, `m_data`=0, `s_ready`=1 (unless `flush`=1);
  - shift register clear held asserted.
  - Mid-word reset discards the partial word with no output.

## Timing
- Bit accepted at edge k: the register holds it after edge k, and `bit_count` reflects it after edge k.
- Latency: the DEPTH-th `s_fire` at edge k gives `m_valid`=1 and valid `m_data` from edge k, i.e. in the next cycle. With `s_valid` held high and `m_ready` held high, one word completes every `DEPTH`+1 cycles.
- `m_data` and `m_valid` stay stable while `m_valid`=1 and `m_ready`=0, for any number of cycles.
- `m_fire` at edge j: `m_valid`=0, `m_data`=0 and `s_ready`=1 after edge j.
- `flush` acts at the edge where it is sampled; its effect is visible the following cycle.
- Reset deassertion: the first state change is possible at the first rising edge after `reset` returns to 1.

## Test plan
- Reset then stream 1,1,0,1,0,1,1,0 with `s_valid`=1 and `m_ready`=0:
  - `m_valid` rises the cycle after the 8th bit, `m_data`=8'b11010110, `bit_count`=8, `s_ready`=0;
  - hold `m_ready`=0 for 5 cycles and `m_data` stays 8'b11010110.
- With a word pending, assert `m_ready` for one cycle: next cycle `m_valid`=0, `m_data`=0, `bit_count`=0, `s_ready`=1. Then stream 8 ones and get `m_data`=8'hFF.
- Toggle `s_valid` (bits 1,0,1,0 with an idle cycle between each): `bit_count` advances only on handshake cycles, reading 1,1,2,2,3,3,4; no spurious shift.
- After 5 bits (`bit_count`=5), assert `flush` with `s_valid`=1: next cycle `bit_count`=0 and the flushed bit is not taken. Then 8 bits 10101010 give `m_data`=8'b10101010.
- Drop `reset` to 0 asynchronously (between edges) mid-word at `bit_count`=3: immediately `bit_count`=0, `m_valid`=0, `m_data`=0. After release, the full 8-bit word is required before `m_valid`.
- Flush and `m_ready` both high in FULL: next cycle IDLE, `m_valid`=0, and `s_ready` returns to 1 once `flush` drops.
